// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// Optional build macro used by the top: SERIAL_ADDSUB_SAT_EN.
package serial_addsub_pkg;

  // Controller states: accepting operands, shifting bits, presenting result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Encoding of the mode input
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_fa.sv
// One-bit combinational full adder, the only arithmetic cell of the serial datapath.
module serial_fa
  import serial_addsub_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  // Sum and carry of the three input bits
  always_comb begin
    o_s    = i_a ^ i_b ^ i_cin;
    o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial, LSB-first two's-complement adder/subtractor with valid/ready
// handshakes. One full-adder cell processes one bit per clock.
// Build option: define SERIAL_ADDSUB_SAT_EN to saturate the result on signed
// overflow (toward the sign of operand A); otherwise the result wraps.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             carry_out
);

  state_t r_state;
  state_t w_nextState;

  logic [WIDTH-1:0] r_aShift;
  logic [WIDTH-1:0] r_bShift;
  logic [WIDTH-2:0] r_sumShift;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_overflow;
  logic             r_carryOut;
  logic [CNT_W-1:0] r_cnt;

  logic             w_sum;
  logic             w_cout;
  logic             w_inReady;
  logic             w_outValid;
  logic             w_accept;
  logic             w_lastBit;
  logic             w_rawOverflow;
  logic [WIDTH-1:0] w_sumNext;
  logic [WIDTH-1:0] w_finalResult;

  // The single full-adder cell, fed by the low bits of the operand shifters
  serial_fa u_fa (
    .i_a    (r_aShift[0]),
    .i_b    (r_bShift[0]),
    .i_cin  (r_carry),
    .o_s    (w_sum),
    .o_cout (w_cout)
  );

  assign w_accept      = in_valid & w_inReady;
  assign w_lastBit     = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_sumNext     = {w_sum, r_sumShift};
  assign w_rawOverflow = r_carry ^ w_cout;

  // On the MSB cycle r_aShift[0] holds the sign bit of operand A
`ifdef SERIAL_ADDSUB_SAT_EN
  // Clamp toward the sign of A when the true result does not fit
  always_comb begin
    w_finalResult = w_sumNext;
    if (w_rawOverflow) begin
      w_finalResult = r_aShift[0] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  // Plain modulo-2^WIDTH result
  always_comb begin
    w_finalResult = w_sumNext;
  end
`endif

  // State register; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake outputs, which depend on state only
  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_outValid  = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReady = 1'b1;
        if (in_valid) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (w_lastBit) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_outValid = 1'b1;
        if (out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Operand capture, bit-serial shifting and final result/flag registration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aShift   <= '0;
      r_bShift   <= '0;
      r_sumShift <= '0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_carryOut <= 1'b0;
    end else if (w_accept) begin
      r_aShift   <= operand_a;
      r_bShift   <= (mode == MODE_SUB) ? ~operand_b : operand_b;
      r_carry    <= (mode != MODE_ADD);
      r_sumShift <= '0;
      r_cnt      <= '0;
    end else if (r_state == RUN) begin
      r_aShift   <= r_aShift >> 1;
      r_bShift   <= r_bShift >> 1;
      r_sumShift <= w_sumNext[WIDTH-1:1];
      r_carry    <= w_cout;
      r_cnt      <= r_cnt + 1'b1;
      if (w_lastBit) begin
        r_result   <= w_finalResult;
        r_overflow <= w_rawOverflow;
        r_carryOut <= w_cout;
      end
    end
  end

  assign in_ready  = w_inReady;
  assign out_valid = w_outValid;
  assign result    = r_result;
  assign overflow  = r_overflow;
  assign carry_out = r_carryOut;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=4): directed cases, backpressure,
// mid-run reset, then every signed pair in both modes with random gaps,
// compared against an integer-arithmetic reference model.
module tb_serial_addsub;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             mode = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] operand_a = '0;
  logic [WIDTH-1:0] operand_b = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             carry_out;

  int checks = 0;
  int errors = 0;

`ifdef SERIAL_ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] EXP_7P1  = 4'b0111;
  localparam logic [WIDTH-1:0] EXP_M8M1 = 4'b1000;
`else
  localparam logic [WIDTH-1:0] EXP_7P1  = 4'b1000;
  localparam logic [WIDTH-1:0] EXP_M8M1 = 4'b0111;
`endif

  serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: true signed arithmetic, then wrap or clamp into WIDTH bits
  task automatic modelAddSub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic m, output logic [WIDTH-1:0] res,
                             output logic ovf, output logic cy);
    int sa;
    int sb;
    int trueVal;
    sa      = int'($signed(a));
    sb      = int'($signed(b));
    trueVal = m ? (sa - sb) : (sa + sb);
    ovf     = (trueVal < -(2 ** (WIDTH - 1))) || (trueVal > (2 ** (WIDTH - 1)) - 1);
    res     = trueVal[WIDTH-1:0];
`ifdef SERIAL_ADDSUB_SAT_EN
    if (ovf) res = (sa < 0) ? 4'b1000 : 4'b0111;
`endif
    if (m) cy = (int'(a) >= int'(b));
    else   cy = ((int'(a) + int'(b)) >= 2 ** WIDTH);
  endtask

  // Present one operand pair and wait (bounded) for it to be accepted
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic m);
    int waitCycles;
    in_valid   = 1'b1;
    operand_a  = a;
    operand_b  = b;
    mode       = m;
    waitCycles = 0;
    while (!in_ready && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) begin
      checkOutput("acceptTimeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Full transaction: accept, latency, result/flags, held stability, release
  task automatic runTxn(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic m,
                        input logic [WIDTH-1:0] expRes, input logic expOvf,
                        input logic expCy, input int holdCycles, input bit noise);
    int lat;
    applyStimulus(a, b, m);
    lat = 0;
    while (!out_valid && lat < WIDTH + 10) begin
      if (noise) begin
        in_valid  = 1'($urandom_range(0, 1));
        operand_a = WIDTH'($urandom);
        operand_b = WIDTH'($urandom);
        mode      = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      checkOutput({tag, "_outTimeout"}, 32'(out_valid), 32'd1);
      return;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(WIDTH));
    checkOutput({tag, "_result"}, 32'(result), 32'(expRes));
    checkOutput({tag, "_overflow"}, 32'(overflow), 32'(expOvf));
    checkOutput({tag, "_carry"}, 32'(carry_out), 32'(expCy));
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      checkOutput({tag, "_hold"}, {28'd0, out_valid, in_ready, overflow, carry_out},
                  {28'd0, 1'b1, 1'b0, expOvf, expCy});
      checkOutput({tag, "_holdResult"}, 32'(result), 32'(expRes));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_release"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    logic [WIDTH-1:0] eRes;
    logic             eOvf;
    logic             eCy;

    #2;
    checkOutput("resetOutputs", {24'd0, out_valid, overflow, carry_out, 1'b0, result},
                32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("resetReady", {30'd0, in_ready, out_valid}, 32'b10);

    runTxn("add3p2", 4'd3, 4'd2, 1'b0, 4'b0101, 1'b0, 1'b0, 0, 1'b0);
    runTxn("add7p1", 4'd7, 4'd1, 1'b0, EXP_7P1, 1'b1, 1'b0, 0, 1'b0);
    runTxn("subM8m1", 4'b1000, 4'd1, 1'b1, EXP_M8M1, 1'b1, 1'b1, 0, 1'b0);
    runTxn("sub5m5", 4'd5, 4'd5, 1'b1, 4'b0000, 1'b0, 1'b1, 0, 1'b0);
    runTxn("sub2m3", 4'd2, 4'd3, 1'b1, 4'b1111, 1'b0, 1'b0, 0, 1'b0);
    runTxn("subM8mM8", 4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b0, 1'b1, 0, 1'b0);
    runTxn("backpressure", 4'b1000, 4'd1, 1'b1, EXP_M8M1, 1'b1, 1'b1, 3, 1'b0);

    // Abort a transaction after two bits have been processed
    applyStimulus(4'd6, 4'd1, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midResetOutputs", {24'd0, out_valid, overflow, carry_out, 1'b0, result},
                32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < WIDTH + 2; i++) begin
      @(negedge clk);
      checkOutput("postResetIdle", {30'd0, out_valid, in_ready}, 32'b01);
    end
    runTxn("addM3pM4", 4'b1101, 4'b1100, 1'b0, 4'b1001, 1'b0, 1'b1, 0, 1'b0);

    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 2 ** WIDTH; a++) begin
        for (int b = 0; b < 2 ** WIDTH; b++) begin
          modelAddSub(WIDTH'(a), WIDTH'(b), 1'(m), eRes, eOvf, eCy);
          repeat ($urandom_range(0, 2)) @(negedge clk);
          runTxn("exhaustive", WIDTH'(a), WIDTH'(b), 1'(m), eRes, eOvf, eCy,
                 int'($urandom_range(0, 2)), 1'b1);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Bit-serial, LSB-first two's-complement adder/subtractor with valid/ready handshakes on both sides.
- Same arithmetic contract as the combinational addsub: result = a + b (mode=0) or a - b (mode=1), plus overflow and carry flags.
- Trades throughput for a single 1-bit full-adder cell.
- Sits between a producer and consumer of operand pairs in the lab datapath.

Parameters:
WIDTH, 4, operand/result width in bits (>= 2)
CNT_W, $clog2(WIDTH), bit-counter width (derived; do not override)

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operand pair presented
in_ready  output  1  block can accept operands
mode  input  1  0 = add, 1 = subtract; sampled with operands
operand_a  input  WIDTH  two's-complement operand A
operand_b  input  WIDTH  two's-complement operand B
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  a±b, low WIDTH bits (or saturated, see option)
overflow  output  1  signed overflow of the operation
carry_out  output  1  carry out of MSB (subtract: 1 = no borrow)

Behaviour:
- Reset (async assert, sync deassert by caller): state=IDLE; in_ready=1 once out of reset; out_valid=0, result=0, overflow=0, carry_out=0; internal shift registers and counter cleared.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, capture A, B^{WIDTH{mode}}, carry=mode, cnt=0 → RUN.
  - RUN: in_ready=0. Each cycle adds bit0 of the A/B shift registers plus carry; sum shifts into result MSB; carry updates; cnt++.
    - On cnt==WIDTH-1: store carry_in of that (MSB) bit. overflow = carry_in_msb ^ carry_out_msb; carry_out = carry_out_msb → DONE.
  - DONE: out_valid=1, outputs held stable. On out_ready → IDLE (out_valid=0 next cycle).
- Latency: operands accepted at edge t0; out_valid rises after edge t0+WIDTH (WIDTH cycles in RUN). Minimum issue interval WIDTH+2 cycles.
- Handshakes:
  - in_ready is combinational from state only (no dependence on in_valid).
  - out_valid, once high, stays high with result/overflow/carry_out unchanged until out_ready is sampled high.
  - Operand inputs are ignored outside IDLE.
- Arithmetic:
  - Mod 2^WIDTH wrap.
  - carry_out is the raw MSB carry of a + ~b + 1 in subtract mode.
  - Flags are only defined while out_valid=1; they hold their last value otherwise.
- Boundaries:
  - a=-2^(W-1), mode=1, b=-2^(W-1): no overflow, result 0.
  - In RUN, in_valid is ignored (no capture, no queueing).
  - rst_n asserted in any state aborts immediately; no partial result emitted.

Optional Feature:
SERIAL_ADDSUB_SAT_EN
- Defined: when overflow=1, result saturates toward the sign of operand A.
  - A non-negative → 0111..1.
  - A negative → 1000..0.
  - overflow and carry_out still report the raw values.
- Undefined: result wraps mod 2^WIDTH.

Decomposition:
- Package serial_addsub_pkg:
  - state enum {IDLE, RUN, DONE}.
  - MODE_ADD=1'b0, MODE_SUB=1'b1.
- Sub-module serial_fa: a 1-bit combinational full adder (a, b, cin → s, cout), instantiated once. Carry flop and shift registers stay in the top.

Test Plan:
1. WIDTH=4, mode=0, a=3, b=2 → out_valid 4 cycles after accept; result=0101, overflow=0, carry_out=0.
2. mode=0, a=7, b=1 → result=1000, overflow=1 (SAT_EN: result=0111); mode=1, a=-8, b=1 → result=0111, overflow=1 (SAT_EN: 1000).
3. mode=1, a=5, b=5 → result=0000, overflow=0, carry_out=1. mode=1, a=2, b=3 → result=1111, carry_out=0.
4. Backpressure: out_ready=0 for 3 cycles after out_valid → result and flags stable, in_ready=0; then out_ready=1 → IDLE, in_ready=1 next cycle.
5. Reset mid-RUN at cnt=2 → out_valid stays 0, outputs 0, in_ready=1 after release. A new transaction a=-3, b=-4, add → result=1001, overflow=0.
6. Exhaustive: all 16×16 signed pairs in both modes, streamed with random in_valid/out_ready gaps. Compare against a±b: low 4 bits (or saturated per macro) and overflow iff true result is outside [-8, 7]; report error count, 0 required.
